// File: rtl/hazard_controller_if.sv
// Hazard controller bundle: pipeline register fields in, stall/flush/forward controls out.
interface hazard_controller_if;
  logic [3:0] RA1D, RA2D;
  logic [3:0] RA1E, RA2E;
  logic [3:0] WA3E, WA3M, WA3W;
  logic       RegWriteE, MemtoRegE;
  logic       RegWriteM, RegWriteW;
  logic       PCSrcD, PCSrcE;
  logic       BranchTakenE;
  logic       StuckE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE;
  logic       FlushD, FlushE, FlushM;
  logic       Busy;

  modport master (
    output RA1D, RA2D, RA1E, RA2E,
    output WA3E, WA3M, WA3W,
    output RegWriteE, MemtoRegE,
    output RegWriteM, RegWriteW,
    output PCSrcD, PCSrcE,
    output BranchTakenE, StuckE,
    input  ForwardAE, ForwardBE,
    input  StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM,
    input  Busy
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E,
    input  WA3E, WA3M, WA3W,
    input  RegWriteE, MemtoRegE,
    input  RegWriteM, RegWriteW,
    input  PCSrcD, PCSrcE,
    input  BranchTakenE, StuckE,
    output ForwardAE, ForwardBE,
    output StallF, StallD, StallE,
    output FlushD, FlushE, FlushM,
    output Busy
  );
endinterface

// File: rtl/hazard_controller.sv
// Hazard controller: load-use stalls, branch flushes,
// multi-cycle execute holds and operand forwarding.
module hazard_controller #(
  parameter int unsigned STUCK_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  hazard_controller_if.slave hz
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MULTI   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT =
    (STUCK_CYCLES > 2) ? 4'(STUCK_CYCLES - 3) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       pcsrc_m_q, pcsrc_m_d;
  logic       pcsrc_w_q;
  logic       mstall;
  logic       ldstall;
  logic       pc_pend;
  logic       ld_match;

  always_comb begin
    mstall  = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        mstall = hz.StuckE & ~hz.BranchTakenE;
        if (mstall) begin
          state_d = (STUCK_CYCLES == 2) ? RELEASE : MULTI;
          cnt_d   = CNT_INIT;
        end
      end
      MULTI: begin
        mstall = 1'b1;
        if (cnt_q == 4'd0) state_d = RELEASE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      // departing op still drives StuckE here
      RELEASE: state_d = RUN;
      default: state_d = RUN;
    endcase
    busy_d    = (state_d != RUN);
    pcsrc_m_d = mstall ? 1'b0 : hz.PCSrcE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      pcsrc_m_q <= 1'b0;
      pcsrc_w_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      pcsrc_m_q <= pcsrc_m_d;
      pcsrc_w_q <= pcsrc_m_q;
    end
  end

  assign ld_match = (hz.WA3E == hz.RA1D) |
                    (hz.WA3E == hz.RA2D);
  assign ldstall  = hz.MemtoRegE & hz.RegWriteE &
                    ld_match & ~mstall;
  assign pc_pend  = hz.PCSrcD | hz.PCSrcE | pcsrc_m_q;

  function automatic logic [1:0] fwd_sel(
    input logic [3:0] ra
  );
    if (hz.RegWriteM && ra == hz.WA3M)      return 2'b10;
    else if (hz.RegWriteW && ra == hz.WA3W) return 2'b01;
    else                                    return 2'b00;
  endfunction

  assign hz.StallF = ~rst & (ldstall | pc_pend | mstall);
  assign hz.StallD = ~rst & (ldstall | mstall);
  assign hz.StallE = ~rst & mstall;
  assign hz.FlushM = ~rst & mstall;
  assign hz.FlushE = ~rst & (ldstall | hz.BranchTakenE) & ~mstall;
  assign hz.FlushD = ~rst & ~mstall &
                     (pc_pend | pcsrc_w_q | hz.BranchTakenE);
  assign hz.ForwardAE = rst ? 2'b00 : fwd_sel(hz.RA1E);
  assign hz.ForwardBE = rst ? 2'b00 : fwd_sel(hz.RA2E);
  assign hz.Busy      = ~rst & busy_q;

endmodule
